// File: rtl/torv32_mem_pkg.sv
// Shared types for the unified memory arbiter.
//   owner_e : which requester owns the RAM access currently on the RAM port
//   state_e : arbiter mode (core traffic, draining, loader-only)
//   RAM_RD_LAT : read latency of the RAM macro in cycles
package torv32_mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2,
        OWN_L    = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    localparam int RAM_RD_LAT = 1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection for the unified memory arbiter.
//   i_elig_i/d/l : requester may be granted this cycle (already masked by mode)
//   i_state      : arbiter mode
//   i_starve_hit : fetch has waited through the maximum number of data grants
//   o_grant      : requester granted this cycle, OWN_NONE when idle
module mem_arb_pick
    import torv32_mem_pkg::*;
(
    input  logic   i_elig_i,
    input  logic   i_elig_d,
    input  logic   i_elig_l,
    input  state_e i_state,
    input  logic   i_starve_hit,
    output owner_e o_grant
);

    // Priority select: data over fetch unless fetch is starved; loader only in LOAD.
    always_comb begin
        o_grant = OWN_NONE;
        case (i_state)
            ST_RUN: begin
                if (i_elig_i && i_starve_hit) begin
                    o_grant = OWN_I;
                end else if (i_elig_d) begin
                    o_grant = OWN_D;
                end else if (i_elig_i) begin
                    o_grant = OWN_I;
                end else begin
                    o_grant = OWN_NONE;
                end
            end
            ST_LOAD: begin
                if (i_elig_l) begin
                    o_grant = OWN_L;
                end else begin
                    o_grant = OWN_NONE;
                end
            end
            ST_DRAIN: o_grant = OWN_NONE;
            default:  o_grant = OWN_NONE;
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous-read RAM among instruction fetch (i_*),
// data load/store (d_*) and the boot loader (l_*).
//   clk, resetn          : clock, asynchronous active-low reset
//   i_req/i_addr         : fetch request; i_rdata/i_ready completion
//   d_req/d_addr/d_wmask/d_wdata : data request (wmask 0 = read); d_rdata/d_ready
//   l_req/l_addr/l_wdata : loader word write; l_ready completion; l_done end of load
//   hold_core            : core must stall while high
//   ram_en/ram_wmask/ram_addr/ram_wdata/ram_rdata : RAM macro port
// A grant in cycle N appears on the RAM port in N+1; the owner's ready pulses in N+2.
module unified_mem_arbiter
    import torv32_mem_pkg::*;
#(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [31:0]   i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    input  logic [3:0]    d_wmask,
    input  logic [31:0]   d_wdata,
    output logic [31:0]   d_rdata,
    output logic          d_ready,
    input  logic          l_req,
    input  logic [AW-1:0] l_addr,
    input  logic [31:0]   l_wdata,
    output logic          l_ready,
    input  logic          l_done,
    output logic          hold_core,
    output logic          ram_en,
    output logic [3:0]    ram_wmask,
    output logic [AW-3:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    localparam int SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    state_e          r_state;
    state_e          w_next_state;
    owner_e          r_owner;        // owner of the access on the RAM port this cycle
    owner_e          w_grant;
    logic            r_i_ready;
    logic            r_d_ready;
    logic            r_l_ready;
    logic            r_hold;
    logic            r_done_pend;
    logic [SCW-1:0]  r_starve_cnt;
    logic            r_ram_en;
    logic [3:0]      r_ram_wmask;
    logic [AW-3:0]   r_ram_addr;
    logic [31:0]     r_ram_wdata;
    logic            w_elig_i;
    logic            w_elig_d;
    logic            w_elig_l;
    logic            w_in_flight;
    logic            w_done;
    logic            w_core_en;
    logic            w_load_en;
    logic            w_starve_hit;
    logic [AW-3:0]   w_addr;
    logic [3:0]      w_wmask;
    logic [31:0]     w_wdata;
    logic            w_unused;

    // Byte-offset bits are architecturally ignored.
    assign w_unused = ^{i_addr[1:0], d_addr[1:0], l_addr[1:0], 1'(RAM_RD_LAT)};

    // A req seen during its own ready cycle still belongs to the finished transfer.
    assign w_elig_i     = i_req && (r_owner != OWN_I) && !r_i_ready;
    assign w_elig_d     = d_req && (r_owner != OWN_D) && !r_d_ready;
    assign w_elig_l     = l_req && (r_owner != OWN_L) && !r_l_ready;
    assign w_in_flight  = (r_owner != OWN_NONE);
    assign w_done       = l_done || r_done_pend;
    assign w_starve_hit = (r_starve_cnt == STARVE_LIM);

    // Mode sequencing and per-mode grant enables.
    always_comb begin
        w_next_state = r_state;
        w_core_en    = 1'b0;
        w_load_en    = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (l_req) begin
                    if (w_in_flight) begin
                        w_next_state = ST_DRAIN;
                    end else begin
                        w_next_state = ST_LOAD;
                    end
                end else begin
                    w_next_state = ST_RUN;
                    w_core_en    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!w_in_flight) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_LOAD: begin
                // Leave only once no loader write is still waiting for its ready.
                if (w_done && (r_owner != OWN_L)) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_LOAD;
                    w_load_en    = 1'b1;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    mem_arb_pick u_pick (
        .i_elig_i     (w_elig_i & w_core_en),
        .i_elig_d     (w_elig_d & w_core_en),
        .i_elig_l     (w_elig_l & w_load_en),
        .i_state      (r_state),
        .i_starve_hit (w_starve_hit),
        .o_grant      (w_grant)
    );

    // RAM command mux for the granted requester.
    always_comb begin
        w_addr  = {(AW-2){1'b0}};
        w_wmask = 4'b0000;
        w_wdata = 32'h0000_0000;
        case (w_grant)
            OWN_I: begin
                w_addr = i_addr[AW-1:2];
            end
            OWN_D: begin
                w_addr  = d_addr[AW-1:2];
                w_wmask = d_wmask;
                w_wdata = d_wdata;
            end
            OWN_L: begin
                w_addr  = l_addr[AW-1:2];
                w_wmask = 4'b1111;
                w_wdata = l_wdata;
            end
            default: begin
                w_addr  = {(AW-2){1'b0}};
                w_wmask = 4'b0000;
                w_wdata = 32'h0000_0000;
            end
        endcase
    end

    // State, access pipeline, readies, hold and starvation tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_RUN;
            r_owner      <= OWN_NONE;
            r_i_ready    <= 1'b0;
            r_d_ready    <= 1'b0;
            r_l_ready    <= 1'b0;
            r_hold       <= 1'b0;
            r_done_pend  <= 1'b0;
            r_starve_cnt <= {SCW{1'b0}};
            r_ram_en     <= 1'b0;
            r_ram_wmask  <= 4'b0000;
            r_ram_addr   <= {(AW-2){1'b0}};
            r_ram_wdata  <= 32'h0000_0000;
        end else begin
            r_state     <= w_next_state;
            r_owner     <= w_grant;
            r_i_ready   <= (r_owner == OWN_I);
            r_d_ready   <= (r_owner == OWN_D);
            r_l_ready   <= (r_owner == OWN_L);
            r_hold      <= (w_next_state != ST_RUN);
            r_done_pend <= (r_state == ST_LOAD) && (w_next_state == ST_LOAD) && w_done;
            r_ram_en    <= (w_grant != OWN_NONE);
            r_ram_wmask <= w_wmask;
            r_ram_addr  <= w_addr;
            r_ram_wdata <= w_wdata;
            if (!i_req || (w_grant == OWN_I)) begin
                r_starve_cnt <= {SCW{1'b0}};
            end else if ((w_grant == OWN_D) && w_elig_i) begin
                r_starve_cnt <= r_starve_cnt + {{(SCW-1){1'b0}}, 1'b1};
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end
        end
    end

    // hold_core rises combinationally with l_req so the core stalls in that same cycle.
    assign hold_core = r_hold | ((r_state == ST_RUN) & l_req);
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign l_ready   = r_l_ready;
    assign i_rdata   = ram_rdata;
    assign d_rdata   = ram_rdata;
    assign ram_en    = r_ram_en;
    assign ram_wmask = r_ram_wmask;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

endmodule
